// File: rtl/mult_arbiter.sv
// mult_arbiter: two-port 8x8 multiplier built on a 4x4 product ROM; `define MULT_ARBITER_RR_EN for round-robin grant, else req0 has fixed priority.
module mult_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_req0_valid,
  output logic        io_req0_ready,
  input  logic [7:0]  io_req0_lhs,
  input  logic [7:0]  io_req0_rhs,
  input  logic        io_req1_valid,
  output logic        io_req1_ready,
  input  logic [7:0]  io_req1_lhs,
  input  logic [7:0]  io_req1_rhs,
  output logic        io_resp_valid,
  input  logic        io_resp_ready,
  output logic [15:0] io_resp_data,
  output logic        io_resp_id
);
  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;
  state_t state, state_n;
  logic [1:0] step;
  logic [15:0] acc, term;
  logic [7:0] lhs, rhs;
  logic id, pick1, accept;
  logic [3:0] nx, ny;
  logic [7:0] rom [256];
  function automatic logic [7:0] nib_mul(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) p = p + (y[i] ? 8'(x) << i : 8'd0);
    return p;
  endfunction
  for (genvar r = 0; r < 256; r++) begin : g_rom
    localparam logic [7:0] A = 8'(r);
    assign rom[r] = nib_mul(A[7:4], A[3:0]);
  end
`ifdef MULT_ARBITER_RR_EN
  logic last;
  always_ff @(posedge clk)
    if (reset) last <= 1'b1;
    else if (accept) last <= pick1;
  assign pick1 = io_req1_valid & (~io_req0_valid | ~last);
`else
  assign pick1 = io_req1_valid & ~io_req0_valid;
`endif
  // partial product of nibble pair s, weighted by 16^(s[1]+s[0])
  assign nx = step[1] ? lhs[7:4] : lhs[3:0];
  assign ny = step[0] ? rhs[7:4] : rhs[3:0];
  assign term = {8'd0, rom[{nx, ny}]} << {step[1] & step[0], step[1] ^ step[0], 2'b00};
  assign accept = io_req0_ready | io_req1_ready;
  always_comb begin
    state_n = state;
    if (state == IDLE && accept) state_n = MUL;
    if (state == MUL && step == 2'd3) state_n = RESP;
    if (state == RESP && io_resp_ready) state_n = IDLE;
    io_req0_ready = state == IDLE && !reset && io_req0_valid && !pick1;
    io_req1_ready = state == IDLE && !reset && pick1;
    io_resp_valid = state == RESP && !reset;
    io_resp_data = io_resp_valid ? acc : 16'd0;
    io_resp_id = io_resp_valid & id;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (reset) begin
      acc <= '0;
      step <= '0;
      lhs <= '0;
      rhs <= '0;
      id <= 1'b0;
    end else if (accept) begin
      lhs <= pick1 ? io_req1_lhs : io_req0_lhs;
      rhs <= pick1 ? io_req1_rhs : io_req0_rhs;
      id <= pick1;
      acc <= '0;
      step <= '0;
    end else if (state == MUL) begin
      acc <= acc + term;
      step <= step + 2'd1;
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: scoreboard bench; model tracks busy/latency/grant pointer and expected products.
module tb_mult_arbiter;
  logic clk = 0, reset = 1;
  logic io_req0_valid = 0, io_req1_valid = 0, io_resp_ready = 0;
  logic [7:0] io_req0_lhs = 0, io_req0_rhs = 0, io_req1_lhs = 0, io_req1_rhs = 0;
  logic io_req0_ready, io_req1_ready, io_resp_valid, io_resp_id;
  logic [15:0] io_resp_data;
  int tests = 0, fails = 0;
  typedef struct { logic id; logic [15:0] p; } exp_t;
  exp_t sbq[$];
  logic grant_log[$];
  bit busy = 0, last_g = 1, done = 0;
  int k = 0;

  mult_arbiter dut (
    .clk(clk), .reset(reset),
    .io_req0_valid(io_req0_valid), .io_req0_ready(io_req0_ready),
    .io_req0_lhs(io_req0_lhs), .io_req0_rhs(io_req0_rhs),
    .io_req1_valid(io_req1_valid), .io_req1_ready(io_req1_ready),
    .io_req1_lhs(io_req1_lhs), .io_req1_rhs(io_req1_rhs),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_data(io_resp_data), .io_resp_id(io_resp_id)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // reference model: one operation in flight, response valid 5 cycles after accept
  always @(negedge clk) begin : mon
    logic [1:0] er;
    logic w1;
    exp_t e;
    if (reset) begin
      check("reset_ready", {30'd0, io_req1_ready, io_req0_ready}, 0);
      check("reset_resp", {14'd0, io_resp_valid, io_resp_id, io_resp_data}, 0);
      busy = 0; k = 0; last_g = 1; sbq.delete();
    end else begin
      if (busy) k++;
`ifdef MULT_ARBITER_RR_EN
      w1 = !last_g;
`else
      w1 = 0;
`endif
      er = 2'b00;
      if (!busy) er = (io_req0_valid && io_req1_valid) ? (w1 ? 2'b10 : 2'b01) : {io_req1_valid, io_req0_valid};
      check("ready", {30'd0, io_req1_ready, io_req0_ready}, {30'd0, er});
      check("resp_valid", {31'd0, io_resp_valid}, {31'd0, busy && k >= 5});
      if (io_resp_valid && sbq.size() > 0) begin
        check("resp_data", {16'd0, io_resp_data}, {16'd0, sbq[0].p});
        check("resp_id", {31'd0, io_resp_id}, {31'd0, sbq[0].id});
      end else if (!io_resp_valid)
        check("resp_idle_zero", {15'd0, io_resp_id, io_resp_data}, 0);
      if (io_resp_valid && io_resp_ready) begin
        check("resp_queue_depth", sbq.size(), 1);
        if (sbq.size() > 0) void'(sbq.pop_front());
        busy = 0;
      end
      if (er != 2'b00) begin
        e.id = er[1];
        e.p = er[1] ? 16'(io_req1_lhs) * 16'(io_req1_rhs) : 16'(io_req0_lhs) * 16'(io_req0_rhs);
        sbq.push_back(e);
        grant_log.push_back(er[1]);
        last_g = er[1];
        busy = 1; k = 0;
      end
    end
  end

  task automatic drive(input int p, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    if (p == 0) begin io_req0_valid = 1; io_req0_lhs = a; io_req0_rhs = b; end
    else begin io_req1_valid = 1; io_req1_lhs = a; io_req1_rhs = b; end
    do begin @(negedge clk); n++; end while (!(p == 0 ? io_req0_ready : io_req1_ready) && n < 400);
    if (n >= 400) begin fails++; tests++; $display("FAIL accept_timeout: port %0d not granted in %0d cycles", p, n); end
    @(posedge clk); #1;
    if (p == 0) io_req0_valid = 0; else io_req1_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin @(posedge clk); n++; end
    #1;
    if (busy) begin fails++; tests++; $display("FAIL drain_timeout: still busy after %0d cycles", n); end
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  initial begin
    io_req0_valid = 1; io_req1_valid = 1;
    repeat (3) @(posedge clk);
    #1 io_req0_valid = 0; io_req1_valid = 0; reset = 0;
    io_resp_ready = 1;
    drive(0, 8'h12, 8'h34); wait_idle();
    drive(1, 8'hFF, 8'hFF); wait_idle();
    drive(1, 8'h00, 8'hA5); wait_idle();
    // both requesters held valid: grant order depends on arbitration mode
    do_reset();
    grant_log.delete();
    io_req0_lhs = 8'h21; io_req0_rhs = 8'h43; io_req1_lhs = 8'h87; io_req1_rhs = 8'h65;
    io_req0_valid = 1; io_req1_valid = 1;
    for (int n = 0; n < 100 && grant_log.size() < 4; n++) @(posedge clk);
    #1 io_req0_valid = 0; io_req1_valid = 0;
    check("grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
`ifdef MULT_ARBITER_RR_EN
      check($sformatf("grant_%0d", i), {31'd0, grant_log[i]}, i % 2);
`else
      check($sformatf("grant_%0d", i), {31'd0, grant_log[i]}, 0);
`endif
    wait_idle();
    // stall in RESP with a competing request pending
    io_resp_ready = 0;
    drive(1, 8'hC3, 8'h5A);
    for (int n = 0; n < 20 && !io_resp_valid; n++) @(posedge clk);
    fork
      drive(0, 8'h9B, 8'h7E);
      begin repeat (10) @(posedge clk); #1 io_resp_ready = 1; end
    join
    wait_idle();
    // reset two cycles into an operation discards it
    drive(0, 8'h55, 8'h66);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    repeat (8) @(posedge clk);
    #1 drive(1, 8'hA7, 8'h3D); wait_idle();
    // randomized traffic on both ports with random backpressure
    done = 0;
    fork
      begin
        fork
          for (int i = 0; i < 500; i++) begin
            repeat ($urandom_range(0, 12)) @(posedge clk);
            #1 drive(0, 8'($urandom), 8'($urandom));
          end
          for (int i = 0; i < 500; i++) begin
            repeat ($urandom_range(0, 12)) @(posedge clk);
            #1 drive(1, 8'($urandom), 8'($urandom));
          end
        join
        done = 1;
      end
      while (!done) begin @(posedge clk); #1 io_resp_ready = $urandom_range(0, 3) != 0; end
    join
    io_resp_ready = 1;
    wait_idle();
    repeat (2) @(posedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 No parameters; operand width fixed at 8 bits, tag width fixed at 1 bit.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 io_req0_valid / io_req1_valid  in  1  requester N presents an operand pair.
REQ-005 io_req0_ready / io_req1_ready  out  1  requester N accepted this cycle.
REQ-006 io_req0_lhs, io_req0_rhs, io_req1_lhs, io_req1_rhs  in  8  unsigned operands.
REQ-007 io_resp_valid  out  1  result available.
REQ-008 io_resp_ready  in  1  consumer accepts result.
REQ-009 io_resp_data  out  16  unsigned product lhs*rhs.
REQ-010 io_resp_id  out  1  index of the requester that issued the operation.

Function
REQ-011 Block SHALL contain one 256-entry x 8-bit product ROM: entry {x[3:0],y[3:0]} = x*y. The ROM is the only multiply resource; no '*' operator.
REQ-012 FSM states SHALL be IDLE, MUL, RESP.
REQ-013 IDLE: io_reqN_ready SHALL be 1 only for the granted N, and only when io_reqN_valid=1; at most one ready per cycle.
REQ-014 On an accept edge (valid & ready), lhs, rhs and id SHALL be captured, acc cleared, step=0, state set to MUL.
REQ-015 MUL: on each cycle, step s (2 bits) SHALL add ROM[{lhs nibble s[1], rhs nibble s[0]}] << 4*(s[1]+s[0]) into the 16-bit acc; after s=3, state set to RESP.
REQ-016 Arithmetic: acc is 16 bits; max 0xFE01, so no overflow handling.
REQ-017 Latency: accept at cycle T -> MUL during T+1..T+4 -> io_resp_valid=1 from T+5.
REQ-018 RESP: io_resp_valid=1, io_resp_data=acc, io_resp_id=captured id, all held stable until io_resp_ready=1; on that edge, state set to IDLE.
REQ-019 No request SHALL be accepted outside IDLE; minimum issue interval is 6 cycles; requesters hold valid and operands until ready.
REQ-020 Outside RESP, io_resp_valid=0, io_resp_data=0, io_resp_id=0.
REQ-021 Requests deasserted before being granted SHALL be dropped silently, with no state change.

Reset
REQ-022 reset=1 SHALL force IDLE, acc=0, step=0, io_resp_valid=0, io_resp_data=0, io_resp_id=0, both readys=0, and last-grant pointer=1.
REQ-023 Reset during MUL or RESP SHALL discard the in-flight operation; no response is produced for it.
REQ-024 Reset takes priority over any simultaneous handshake.

Configuration
REQ-025 Macro MULT_ARBITER_RR_EN defined: round-robin arbitration. When both requesters are valid in IDLE, the one not last granted wins; the pointer updates on each accept; a single valid requester always wins.
REQ-026 MULT_ARBITER_RR_EN undefined: fixed priority, req0 always beats req1; the pointer logic is absent.

Verification
REQ-027 req0 lhs=0x12 rhs=0x34 alone -> io_req0_ready pulse at T, io_resp_valid at T+5, data=0x03A8, id=0.
REQ-028 req1 lhs=0xFF rhs=0xFF -> data=0xFE01, id=1; lhs=0x00 rhs=0xA5 -> data=0x0000.
REQ-029 Both valid continuously, RR_EN defined, resp_ready=1 -> grants alternate 0,1,0,1 starting with 0; RR_EN undefined -> all grants to req0.
REQ-030 resp_ready held 0 for 10 cycles in RESP -> io_resp_valid, data and id stable; no readys asserted; IDLE one cycle after resp_ready=1.
REQ-031 reset pulsed at T+2 of an operation -> next cycle IDLE with all outputs 0; no response emitted; a new request completes correctly.
REQ-032 Random 1000 operand pairs on both ports -> every response equals lhs*rhs of the tagged requester, in accept order.
